multicycle_chunked_adder: RTL and testbench
===========================================

// Module: multicycle_chunked_adder
// PURPOSE
//  Parametrised, sequential successor to the single-cycle behavioural full adder.
//  Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, with a ripple carry held in a register.
//  Offers start/busy/done handshake plus carry, signed-overflow and zero flags.
//  Sits under the ALU/datapath wherever a narrow, slow adder beats a wide single-cycle one.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be an integer multiple of CHUNK
//  CHUNK    8  bits added per cycle; CHUNK==WIDTH gives a 1-chunk (single-pass) adder
// PORTS
//  clk       in   1      single clock, rising edge
//  reset     in   1      synchronous, active-high reset
//  start     in   1      request; sampled only when busy==0
//  sub       in   1      0: a+b+carryin; 1: a-b-carryin
//  a         in   WIDTH  operand A, captured on accepted start
//  b         in   WIDTH  operand B, captured on accepted start
//  carryin   in   1      carry in (add) / borrow in (sub), captured on accepted start
//  busy      out  1      high while chunks are being processed
//  done      out  1      one-cycle pulse: results valid
//  sum       out  WIDTH  result, held from done until next accepted start
//  carryout  out  1      raw carry out of the MSB (sub: 1 = no borrow)
//  overflow  out  1      two's-complement signed overflow
//  zero      out  1      sum == 0
// BEHAVIOUR
//  - Reset: the only reset is synchronous and active-high.
//    Reset forces state IDLE; busy, done, sum, carryout, overflow and zero are all 0. Operand registers are cleared.
//  - NCHUNK = WIDTH/CHUNK. States: IDLE, RUN, DONE.
//  - IDLE: at an edge with start=1, capture a, b_eff = sub ? ~b : b, and c = sub ? ~carryin : carryin.
//    Clear chunk index k=0; go to RUN. busy=1 from the next cycle.
//  - RUN: each edge adds chunk k of a and b_eff with c, writes sum chunk k, updates c, and sets k=k+1.
//    After the edge processing k=NCHUNK-1, go to DONE.
//  - DONE: lasts one cycle with done=1 and busy=0.
//    carryout = final c; overflow = carry into MSB XOR carry out of MSB; zero = (sum==0).
//  - Latency: start accepted at edge 0 -> done high in the cycle after edge NCHUNK (NCHUNK+1 cycles start-to-done).
//  - start while busy=1 is ignored and is not queued.
//  - start=1 during the DONE cycle is accepted: DONE -> RUN directly, with no IDLE gap; throughput is 1 op per NCHUNK+1 cycles.
//  - Outputs hold after DONE -> IDLE until the next accepted start. sum is undefined-but-stable while busy; flags update only at DONE.
//  - Arithmetic is modulo 2^WIDTH; there are no sticky flags.
//  - reset mid-RUN aborts the operation: no done pulse, and all outputs return to reset values at that edge.
//  - Input changes on a/b/sub/carryin after capture have no effect on the operation in flight.
// STRUCTURE
//  - Shared header adder_defs.vh holds:
//    - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
//    - the gate-delay `defines already used by the gate-level adders
//  - Sub-module adder_chunk #(CHUNK): combinational. Ports: x, y, cin -> s, cout, cmsb (carry into MSB, for overflow).
//    Instantiated once; the top holds the FSM, k counter, carry register and shift/indexed chunk muxing.
// TESTING (WIDTH=32, CHUNK=8 unless noted)
//  1. start, a=0x0000000B, b=0, carryin=0, sub=0 -> done 5 cycles after start; sum=0x0000000B, carryout=0, overflow=0, zero=0.
//  2. a=0xFFFFFFFF, b=0x00000001, carryin=0 -> sum=0, carryout=1, zero=1, overflow=0 (inter-chunk carry ripple).
//  3. a=0x7FFFFFFF, b=1 -> sum=0x80000000, overflow=1, carryout=0.
//     Then sub=1, a=5, b=7, carryin=0 -> sum=0xFFFFFFFE, carryout=0, overflow=0.
//  4. Handshake: start pulsed again at cycles 2 and 3 of an operation -> ignored, one done only.
//     start held during DONE -> second op accepted, done again 5 cycles later.
//     Inputs changed mid-op -> result uses captured values.
//  5. reset asserted in RUN at k=2 -> next cycle busy=0, done=0, sum=0, with no later done pulse.
//     A new op then completes correctly.
//  6. Parameter sweep CHUNK=32 and CHUNK=4 with 1000 random a/b/sub/carryin vs reference {carryout,sum}=a+b_eff+c.
//     Latency is checked as NCHUNK+1 cycles.

Source files
------------

// File: rtl/multicycle_chunked_adder_pkg.sv
// Shared definitions for the multicycle chunked adder.
//   state_t    : controller states (IDLE=0, RUN=1, DONE=2)
//   idx_width  : width of the chunk index counter for a given chunk count
package multicycle_chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-chunk adder still needs a 1-bit index so the counter stays legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multicycle_chunked_adder_chunk.sv
// Combinational CHUNK-bit adder slice used once per clock by the top.
// Ports:
//   x, y  in   CHUNK  operand chunks (y already inverted for subtraction)
//   cin   in   1      carry into the slice
//   s     out  CHUNK  slice sum
//   cout  out  1      carry out of the slice MSB
//   cmsb  out  1      carry into the slice MSB (used for signed overflow)
module multicycle_chunked_adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] full;

  assign full = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  assign s    = full[CHUNK-1:0];
  assign cout = full[CHUNK];
  // The MSB sum bit is x^y^carry_in, so the carry into it falls out directly.
  assign cmsb = s[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];

endmodule

// File: rtl/multicycle_chunked_adder.sv
// Sequential adder/subtractor processing CHUNK bits per clock, LSB chunk first.
// WIDTH must be an integer multiple of CHUNK.
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous, active-high reset
//   start     in   1      request, sampled only when not busy (IDLE or DONE)
//   sub       in   1      0: a+b+carryin, 1: a-b-carryin
//   a, b      in   WIDTH  operands, captured on an accepted start
//   carryin   in   1      carry/borrow in, captured on an accepted start
//   busy      out  1      high while chunks are being processed
//   done      out  1      one-cycle pulse, results valid
//   sum       out  WIDTH  result, held from done until the next accepted start
//   carryout  out  1      raw carry out of the MSB (sub: 1 = no borrow)
//   overflow  out  1      two's-complement signed overflow
//   zero      out  1      sum == 0
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one chunk added per edge, index k counts 0..NCHUNK-1
// DONE  | single cycle with done=1; a start here goes straight to RUN
module multicycle_chunked_adder
  import multicycle_chunked_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = idx_width(NCHUNK);
  localparam logic [KW-1:0]    KLAST = KW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             c_r;
  logic [KW-1:0]    k;

  logic [31:0]      base;
  logic [CHUNK-1:0] x_k;
  logic [CHUNK-1:0] y_k;
  logic [CHUNK-1:0] s_k;
  logic             cout_k;
  logic             cmsb_k;
  logic [WIDTH-1:0] sum_nxt;

  // Bit offset of the current chunk; shifts keep the select free of index-width issues.
  assign base = 32'(k) * 32'(CHUNK);
  assign x_k  = CHUNK'(a_r >> base);
  assign y_k  = CHUNK'(b_r >> base);

  multicycle_chunked_adder_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .x   (x_k),
    .y   (y_k),
    .cin (c_r),
    .s   (s_k),
    .cout(cout_k),
    .cmsb(cmsb_k)
  );

  // sum with chunk k replaced; used both for the register update and the zero flag.
  always_comb begin
    sum_nxt = (sum & ~(CMASK << base)) | (WIDTH'(s_k) << base);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      c_r      <= 1'b0;
      k        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            c_r   <= sub ? ~carryin : carryin;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum <= sum_nxt;
          c_r <= cout_k;
          k   <= k + KW'(1);
          if (k == KLAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            carryout <= cout_k;
            overflow <= cmsb_k ^ cout_k;
            zero     <= (sum_nxt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_chunked_adder.sv
// Testbench: three instances (CHUNK=8, 32, 4) at WIDTH=32 checked against an
// arithmetic reference model; handshake and reset cases run on the CHUNK=8 one.
module tb_multicycle_chunked_adder;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ov;
    logic         zero;
  } res_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [2:0]     start = 3'b000;
  logic           sub = 1'b0;
  logic           carryin = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2:0]     busy;
  logic [2:0]     done;
  logic [2:0]     carryout;
  logic [2:0]     overflow;
  logic [2:0]     zero;
  logic [3*W-1:0] sums;

  int    errors = 0;
  int    checks = 0;
  int    nch [3] = '{4, 1, 8};
  string nm [3] = '{"c8", "c32", "c4"};
  int    edge_no;
  int    dcnt [3];
  int    lat1 [3];
  int    lat2 [3];
  logic [W-1:0] s1 [3];
  logic [W-1:0] s2 [3];
  logic  c1 [3], v1 [3], z1 [3];
  logic  c2 [3], v2 [3], z2 [3];

  always #5 clk = ~clk;

  multicycle_chunked_adder #(.WIDTH(W), .CHUNK(8)) u_c8 (
    .clk(clk), .reset(reset), .start(start[0]), .sub(sub), .a(a), .b(b),
    .carryin(carryin), .busy(busy[0]), .done(done[0]), .sum(sums[0*W +: W]),
    .carryout(carryout[0]), .overflow(overflow[0]), .zero(zero[0])
  );

  multicycle_chunked_adder #(.WIDTH(W), .CHUNK(32)) u_c32 (
    .clk(clk), .reset(reset), .start(start[1]), .sub(sub), .a(a), .b(b),
    .carryin(carryin), .busy(busy[1]), .done(done[1]), .sum(sums[1*W +: W]),
    .carryout(carryout[1]), .overflow(overflow[1]), .zero(zero[1])
  );

  multicycle_chunked_adder #(.WIDTH(W), .CHUNK(4)) u_c4 (
    .clk(clk), .reset(reset), .start(start[2]), .sub(sub), .a(a), .b(b),
    .carryin(carryin), .busy(busy[2]), .done(done[2]), .sum(sums[2*W +: W]),
    .carryout(carryout[2]), .overflow(overflow[2]), .zero(zero[2])
  );

  // Reference: plain integer arithmetic on the operands as given.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input logic ci);
    res_t       r;
    longint     sx, sy, sv;
    logic [W:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!s) begin
      u      = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
      r.cout = u[W];
      sv     = sx + sy + longint'(ci);
    end else begin
      u      = {1'b0, x} - {1'b0, y} - (W+1)'(ci);
      r.cout = ({1'b0, x} >= ({1'b0, y} + (W+1)'(ci)));
      sv     = sx - sy - longint'(ci);
    end
    r.sum  = u[W-1:0];
    r.ov   = (sv > SMAX) || (sv < SMIN);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_watch();
    edge_no = 0;
    for (int i = 0; i < 3; i++) begin
      dcnt[i] = 0;
      lat1[i] = -1;
      lat2[i] = -1;
    end
  endtask

  // One clock; samples 1 time unit after the edge and records done pulses.
  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
    for (int i = 0; i < 3; i++) begin
      if (done[i] === 1'b1) begin
        if (dcnt[i] == 0) begin
          lat1[i] = edge_no; s1[i] = sums[i*W +: W];
          c1[i] = carryout[i]; v1[i] = overflow[i]; z1[i] = zero[i];
        end else begin
          lat2[i] = edge_no; s2[i] = sums[i*W +: W];
          c2[i] = carryout[i]; v2[i] = overflow[i]; z2[i] = zero[i];
        end
        dcnt[i]++;
      end
    end
  endtask

  // Drives operands with start, lets the accepting edge pass, restarts the watch.
  task automatic launch(input logic [2:0] mask, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic ci, input bit hold);
    a = x; b = y; sub = s; carryin = ci; start = mask;
    @(posedge clk);
    #1;
    if (!hold) start = 3'b000;
    clear_watch();
  endtask

  task automatic check_op(input int i, input string tag, input res_t e);
    check({tag, " ", nm[i], " done_count"}, 64'(dcnt[i]), 64'(1));
    check({tag, " ", nm[i], " latency"},    64'(lat1[i]), 64'(nch[i]));
    check({tag, " ", nm[i], " sum"},        64'(s1[i]),   64'(e.sum));
    check({tag, " ", nm[i], " carryout"},   64'(c1[i]),   64'(e.cout));
    check({tag, " ", nm[i], " overflow"},   64'(v1[i]),   64'(e.ov));
    check({tag, " ", nm[i], " zero"},       64'(z1[i]),   64'(e.zero));
  endtask

  task automatic run_all(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input logic ci);
    res_t e;
    e = model(x, y, s, ci);
    launch(3'b111, x, y, s, ci, 1'b0);
    repeat (10) step();
    for (int i = 0; i < 3; i++) check_op(i, tag, e);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, " ", nm[i], " busy"},     64'(busy[i]),          64'(0));
      check({tag, " ", nm[i], " done"},     64'(done[i]),          64'(0));
      check({tag, " ", nm[i], " sum"},      64'(sums[i*W +: W]),   64'(0));
      check({tag, " ", nm[i], " carryout"}, 64'(carryout[i]),      64'(0));
      check({tag, " ", nm[i], " overflow"}, 64'(overflow[i]),      64'(0));
      check({tag, " ", nm[i], " zero"},     64'(zero[i]),          64'(0));
    end
  endtask

  initial begin
    res_t         e, e2;
    logic [W-1:0] rx, ry;
    logic         rs, rc;

    clear_watch();
    reset = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    reset = 1'b0;

    run_all("t1 small add",      32'h0000_000B, 32'h0000_0000, 1'b0, 1'b0);
    run_all("t2 ripple carry",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_all("t3 signed ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_all("t3 sub negative",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
    run_all("sub with borrow",   32'h1234_5678, 32'h1234_5677, 1'b1, 1'b1);
    run_all("neg ovf on sub",    32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    run_all("add with carryin",  32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b1);

    // Restarts while busy are ignored; operand changes after capture are ignored.
    e = model(32'h1234_5678, 32'h0101_0101, 1'b0, 1'b0);
    launch(3'b001, 32'h1234_5678, 32'h0101_0101, 1'b0, 1'b0, 1'b0);
    step();
    check("ignore busy mid-op", 64'(busy[0]), 64'(1));
    a = 32'hDEAD_BEEF; b = 32'hFFFF_FFFF; sub = 1'b1; carryin = 1'b1;
    start = 3'b001;
    step();
    step();
    start = 3'b000;
    repeat (9) step();
    check_op(0, "ignore", e);

    // start held through DONE: second op follows with no idle gap.
    e  = model(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
    e2 = model(32'h0000_0009, 32'h0000_0009, 1'b1, 1'b0);
    launch(3'b001, 32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 1'b1);
    a = 32'h0000_0009; b = 32'h0000_0009; sub = 1'b1; carryin = 1'b0;
    repeat (4) step();
    check("b2b busy in done", 64'(busy[0]), 64'(0));
    check("b2b done pulse",   64'(done[0]), 64'(1));
    step();
    start = 3'b000;
    check("b2b busy after accept", 64'(busy[0]), 64'(1));
    repeat (8) step();
    check("b2b done_count", 64'(dcnt[0]), 64'(2));
    check("b2b lat1",       64'(lat1[0]), 64'(4));
    check("b2b lat2",       64'(lat2[0]), 64'(9));
    check("b2b sum1",       64'(s1[0]),   64'(e.sum));
    check("b2b sum2",       64'(s2[0]),   64'(e2.sum));
    check("b2b carry2",     64'(c2[0]),   64'(e2.cout));
    check("b2b ovf2",       64'(v2[0]),   64'(e2.ov));
    check("b2b zero2",      64'(z2[0]),   64'(e2.zero));

    // Reset in RUN with k=2 aborts: outputs cleared, no done pulse afterwards.
    launch(3'b001, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_outputs("abort");
    repeat (8) step();
    check("abort no done", 64'(dcnt[0]), 64'(0));
    run_all("after abort", 32'h0F0F_0F0F, 32'h1010_1010, 1'b0, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ry = rx;
      if ($urandom_range(0, 15) == 0) rx = 32'hFFFF_FFFF;
      run_all($sformatf("rand%0d", n), rx, ry, rs, rc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
